// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : In-order circular buffer between the PC/fetch stage and decode.
//             Accepts up to 3 consecutive instructions per cycle, presents up
//             to the 3 oldest entries per cycle, and raises stall_pc whenever
//             room for a full 3-wide group cannot be guaranteed. A flush empties
//             the queue on the edge that ends the flush cycle.
//  Ports    : clk        - clock, all state updates on the rising edge
//             rst        - asynchronous active-low reset
//             valid_in   - per-slot valid of incoming group (prefix mask)
//             pc_in      - PC of each incoming slot, slot 0 oldest
//             inst_in    - instruction word of each incoming slot
//             flush      - mispredict flush, priority over all other events
//             ready_dec  - decode takes the whole presented group this cycle
//             valid_out  - per-slot valid of presented group (prefix mask)
//             pc_out     - PC of presented slots, slot 0 oldest
//             inst_out   - instruction word of presented slots
//             stall_pc   - PC generator must hold its current group
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      valid_in,
  input  logic [2:0][31:0] pc_in,
  input  logic [2:0][31:0] inst_in,
  input  logic            flush,
  input  logic            ready_dec,
  output logic [2:0]      valid_out,
  output logic [2:0][31:0] pc_out,
  output logic [2:0][31:0] inst_out,
  output logic            stall_pc
);

  // Stall as soon as fewer than 3 free entries remain.
  localparam logic [PTR_W:0] STALL_THR = (PTR_W+1)'(DEPTH - 3);
  localparam logic [PTR_W:0] GROUP_MAX = (PTR_W+1)'(3);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] pc_mem_d   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] inst_mem_d [DEPTH];

  logic       enq_en;
  logic       deq_en;
  logic [1:0] n_enq;
  logic [1:0] n_deq;
  logic [1:0] n_avail;

  // Back-pressure depends on registered occupancy only, so the PC generator
  // sees no combinational path from this cycle's valid_in or ready_dec.
  assign stall_pc = (count_q > STALL_THR);

  // --------------------------------------------------------------------------
  // Presentation and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    n_avail = (count_q >= GROUP_MAX) ? 2'd3 : count_q[1:0];

    valid_out = 3'b000;
    if (!flush) begin
      case (n_avail)
        2'd0:    valid_out = 3'b000;
        2'd1:    valid_out = 3'b001;
        2'd2:    valid_out = 3'b011;
        default: valid_out = 3'b111;
      endcase
    end

    for (int i = 0; i < 3; i++) begin
      pc_out[i]   = pc_mem_q[head_q + PTR_W'(i)];
      inst_out[i] = inst_mem_q[head_q + PTR_W'(i)];
    end

    enq_en = !flush && !stall_pc;
    deq_en = ready_dec && !flush;

    n_enq = enq_en ? (2'(valid_in[0]) + 2'(valid_in[1]) + 2'(valid_in[2])) : 2'd0;
    // valid_out is a prefix of length n_avail, so its popcount is n_avail.
    n_deq = deq_en ? n_avail : 2'd0;
  end

  // --------------------------------------------------------------------------
  // Pointer / occupancy next-state
  // --------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: slot i lands at tail+i, wrapping naturally through the
  // PTR_W-bit index so a group may straddle the end of the array.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    for (int i = 0; i < 3; i++) begin
      if (enq_en && valid_in[i]) begin
        pc_mem_d[tail_q + PTR_W'(i)]   = pc_in[i];
        inst_mem_d[tail_q + PTR_W'(i)] = inst_in[i];
      end
    end
  end

  // Contents are only observable through valid_out, so no reset is needed.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. A vector table drives the
//             main sequences and supplies expected valid_out / stall_pc; a
//             queue-based scoreboard supplies the expected presented data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 8;

  logic            clk;
  logic            rst;
  logic [2:0]      valid_in;
  logic [2:0][31:0] pc_in;
  logic [2:0][31:0] inst_in;
  logic            flush;
  logic            ready_dec;
  logic [2:0]      valid_out;
  logic [2:0][31:0] pc_out;
  logic [2:0][31:0] inst_out;
  logic            stall_pc;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .pc_in     (pc_in),
    .inst_in   (inst_in),
    .flush     (flush),
    .ready_dec (ready_dec),
    .valid_out (valid_out),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .stall_pc  (stall_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only contiguous-prefix valid patterns are legal stimulus.
  always @(posedge clk) begin
    if (rst) begin
      assert (valid_in == 3'b000 || valid_in == 3'b001 ||
              valid_in == 3'b011 || valid_in == 3'b111)
        else $error("illegal valid_in pattern %b", valid_in);
    end
  end

  typedef struct {
    logic [2:0]  vin;
    logic [31:0] base;
    logic        fl;
    logic        rdy;
    logic [2:0]  ev;   // expected valid_out
    logic        es;   // expected stall_pc
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t tbl [29];
  ent_t sb [$];
  int   tests;
  int   fails;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h5A5A, ~pc[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check shortly after, then advance the
  // scoreboard on the following rising edge.
  task automatic step(input logic [2:0] vin, input logic [31:0] base,
                      input logic fl, input logic rdy,
                      input logic [2:0] ev, input logic es, input string nm);
    int   n;
    bit   m_stall;
    ent_t e;
    @(negedge clk);
    valid_in  = vin;
    flush     = fl;
    ready_dec = rdy;
    for (int i = 0; i < 3; i++) begin
      pc_in[i]   = base + 32'(4 * i);
      inst_in[i] = mk_inst(base + 32'(4 * i));
    end
    #1;
    chk({nm, " valid_out"}, 32'(valid_out), 32'(ev));
    chk({nm, " stall_pc"}, 32'(stall_pc), 32'(es));
    n = (sb.size() > 3) ? 3 : sb.size();
    for (int i = 0; i < 3; i++) begin
      if (ev[i] && i < n) begin
        chk($sformatf("%s pc_out[%0d]", nm, i), pc_out[i], sb[i].pc);
        chk($sformatf("%s inst_out[%0d]", nm, i), inst_out[i], sb[i].inst);
      end
    end
    m_stall = (sb.size() > DEPTH - 3);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (rdy) repeat (n) e = sb.pop_front();
      if (!m_stall) begin
        for (int i = 0; i < 3; i++) begin
          if (vin[i]) begin
            e.pc   = base + 32'(4 * i);
            e.inst = mk_inst(e.pc);
            sb.push_back(e);
          end
        end
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    valid_in  = 3'b000;
    flush     = 1'b0;
    ready_dec = 1'b0;
    pc_in     = '0;
    inst_in   = '0;

    //            vin     base       fl    rdy   ev      es
    // single group pass-through
    tbl[0]  = '{3'b111, 32'h1000, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[1]  = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b0};
    tbl[2]  = '{3'b000, 32'h0,    1'b0, 1'b0, 3'b000, 1'b0};
    // fill to stall, dropped group re-presented
    tbl[3]  = '{3'b111, 32'h1100, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[4]  = '{3'b111, 32'h1200, 1'b0, 1'b0, 3'b111, 1'b0};
    tbl[5]  = '{3'b111, 32'h2000, 1'b0, 1'b0, 3'b111, 1'b1};
    tbl[6]  = '{3'b111, 32'h2000, 1'b0, 1'b1, 3'b111, 1'b1};
    tbl[7]  = '{3'b111, 32'h2000, 1'b0, 1'b0, 3'b111, 1'b0};
    tbl[8]  = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b1};
    tbl[9]  = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b0};
    tbl[10] = '{3'b000, 32'h0,    1'b0, 1'b0, 3'b000, 1'b0};
    // move pointers to 7
    tbl[11] = '{3'b111, 32'h2100, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[12] = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b0};
    // wrap-around group at entries 7,0,1
    tbl[13] = '{3'b111, 32'h3000, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[14] = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b0};
    // simultaneous enqueue/dequeue at count 4
    tbl[15] = '{3'b111, 32'h4000, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[16] = '{3'b001, 32'h4100, 1'b0, 1'b0, 3'b111, 1'b0};
    tbl[17] = '{3'b011, 32'h4200, 1'b0, 1'b1, 3'b111, 1'b0};
    tbl[18] = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b0};
    // partial presentation widths 1 and 2
    tbl[19] = '{3'b001, 32'h4300, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[20] = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b001, 1'b0};
    tbl[21] = '{3'b011, 32'h4400, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[22] = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b011, 1'b0};
    // flush at count 5 with traffic on both sides
    tbl[23] = '{3'b111, 32'h5000, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[24] = '{3'b011, 32'h5100, 1'b0, 1'b0, 3'b111, 1'b0};
    tbl[25] = '{3'b111, 32'h5200, 1'b1, 1'b1, 3'b000, 1'b0};
    tbl[26] = '{3'b000, 32'h0,    1'b0, 1'b0, 3'b000, 1'b0};
    tbl[27] = '{3'b111, 32'h5300, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[28] = '{3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b0};

    // Reset held for two cycles, then released.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_reset valid_out", 32'(valid_out), 32'h0);
    chk("in_reset stall_pc", 32'(stall_pc), 32'h0);
    rst = 1'b1;
    #1;
    chk("post_reset count", 32'(dut.count_q), 32'h0);
    chk("post_reset valid_out", 32'(valid_out), 32'h0);
    chk("post_reset stall_pc", 32'(stall_pc), 32'h0);

    for (int r = 0; r < 29; r++) begin
      step(tbl[r].vin, tbl[r].base, tbl[r].fl, tbl[r].rdy, tbl[r].ev, tbl[r].es,
           $sformatf("row%0d", r));
      #1;
      if (r == 13) chk("wrap tail", 32'(dut.tail_q), 32'h2);
      if (r == 14) chk("wrap head", 32'(dut.head_q), 32'h2);
      if (r == 17) chk("enq_deq count", 32'(dut.count_q), 32'h3);
      if (r == 24) chk("pre_flush count", 32'(dut.count_q), 32'h5);
      if (r == 25) begin
        chk("flush count", 32'(dut.count_q), 32'h0);
        chk("flush head", 32'(dut.head_q), 32'h0);
        chk("flush tail", 32'(dut.tail_q), 32'h0);
      end
    end

    // Asynchronous reset mid-fill at count 5.
    step(3'b111, 32'h6000, 1'b0, 1'b0, 3'b000, 1'b0, "midrst_a");
    step(3'b011, 32'h6100, 1'b0, 1'b0, 3'b111, 1'b0, "midrst_b");
    @(negedge clk);
    valid_in = 3'b000;
    #1;
    chk("midrst pre count", 32'(dut.count_q), 32'h5);
    chk("midrst pre valid_out", 32'(valid_out), 32'h7);
    rst = 1'b0;
    #1;
    chk("midrst valid_out", 32'(valid_out), 32'h0);
    chk("midrst stall_pc", 32'(stall_pc), 32'h0);
    chk("midrst count", 32'(dut.count_q), 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(3'b000, 32'h0,    1'b0, 1'b1, 3'b000, 1'b0, "after_rst_idle");
    step(3'b111, 32'h7000, 1'b0, 1'b0, 3'b000, 1'b0, "after_rst_enq");
    step(3'b000, 32'h0,    1'b0, 1'b1, 3'b111, 1'b0, "after_rst_deq");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
